mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, word-organised data memory with byte/half
// access, misalignment detection, branch resolution and the MEM/WB register.
module mem_stage #(
    parameter int DMEM_WORDS = 256,
    parameter int AW         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] REG_DATA2_EX_FINAL,
    input  logic [31:0] PC_Branch_EX,
    input  logic [4:0]  RD_EX,
    input  logic [2:0]  FUNCT3_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Branch_EX,
    input  logic        ZERO_EX,
    input  logic        FLUSH,
    output logic [31:0] ALU_OUT_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic [31:0] PC_Branch_MEM,
    output logic        PCSrc_MEM,
    output logic        MISALIGN_MEM,
    output logic [31:0] ALU_DATA_WB,
    output logic [4:0]  RD_WB,
    output logic        RegWrite_WB
);

    // Pick and extend the loaded lane; misaligned accesses return the raw word.
    function automatic logic [31:0] load_select(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane, input logic misal);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        if (misal) begin
            r = word;
        end else begin
            case (f3)
                3'b000:  r = {{24{b[7]}}, b};
                3'b001:  r = {{16{h[15]}}, h};
                3'b100:  r = {24'h000000, b};
                3'b101:  r = {16'h0000, h};
                default: r = word;
            endcase
        end
        return r;
    endfunction

    // Merge store data into the old word, leaving unaddressed bytes intact.
    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'b00:   r[7:0]   = data[7:0];
                    2'b01:   r[15:8]  = data[7:0];
                    2'b10:   r[23:16] = data[7:0];
                    default: r[31:24] = data[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = data[15:0];
                end else begin
                    r[15:0] = data[15:0];
                end
            end
            default: r = data;
        endcase
        return r;
    endfunction

    logic [31:0] alu_out_r, store_data_r, pc_branch_r;
    logic [4:0]  rd_r;
    logic [2:0]  funct3_r;
    logic        reg_write_r, mem_to_reg_r, mem_read_r, mem_write_r, branch_r, zero_r;
    logic [31:0] alu_data_wb_r;
    logic [4:0]  rd_wb_r;
    logic        reg_write_wb_r;

    logic [31:0] dmem_r [DMEM_WORDS];

    logic [AW-1:0] mem_idx_s;
    logic [31:0]   rdata_s;
    logic          misalign_s;
    logic [31:0]   load_data_s;

    // Address decode, combinational read and alignment check for the MEM cycle.
    always_comb begin
        mem_idx_s   = alu_out_r[AW+1:2];
        rdata_s     = dmem_r[mem_idx_s];
        misalign_s  = (mem_read_r | mem_write_r) &
                      (((funct3_r[1:0] == 2'b01) & alu_out_r[0]) |
                       (funct3_r[1] & (alu_out_r[1:0] != 2'b00)));
        load_data_s = load_select(rdata_s, funct3_r, alu_out_r[1:0], misalign_s);
    end

    // EX/MEM register; a flush squashes every side-effecting control bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_r    <= 32'h0000_0000;
            store_data_r <= 32'h0000_0000;
            pc_branch_r  <= 32'h0000_0000;
            rd_r         <= 5'd0;
            funct3_r     <= 3'b000;
            reg_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            branch_r     <= 1'b0;
            zero_r       <= 1'b0;
        end else begin
            alu_out_r    <= ALU_OUT_EX;
            store_data_r <= REG_DATA2_EX_FINAL;
            pc_branch_r  <= PC_Branch_EX;
            rd_r         <= RD_EX;
            funct3_r     <= FUNCT3_EX;
            mem_to_reg_r <= MemtoReg_EX;
            zero_r       <= ZERO_EX;
            reg_write_r  <= RegWrite_EX & ~FLUSH;
            mem_read_r   <= MemRead_EX  & ~FLUSH;
            mem_write_r  <= MemWrite_EX & ~FLUSH;
            branch_r     <= Branch_EX   & ~FLUSH;
        end
    end

    // Data memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!reset && mem_write_r && !misalign_s) begin
            dmem_r[mem_idx_s] <= store_merge(rdata_s, store_data_r, funct3_r[1:0], alu_out_r[1:0]);
        end
    end

    // MEM/WB register; the read above sees memory before this edge's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_data_wb_r  <= 32'h0000_0000;
            rd_wb_r        <= 5'd0;
            reg_write_wb_r <= 1'b0;
        end else begin
            alu_data_wb_r  <= mem_to_reg_r ? load_data_s : alu_out_r;
            rd_wb_r        <= rd_r;
            reg_write_wb_r <= reg_write_r;
        end
    end

    assign ALU_OUT_MEM   = alu_out_r;
    assign RD_MEM        = rd_r;
    assign RegWrite_MEM  = reg_write_r;
    assign PC_Branch_MEM = pc_branch_r;
    assign PCSrc_MEM     = branch_r & zero_r;
    assign MISALIGN_MEM  = misalign_s;
    assign ALU_DATA_WB   = alu_data_wb_r;
    assign RD_WB         = rd_wb_r;
    assign RegWrite_WB   = reg_write_wb_r;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised bench for mem_stage against a byte-addressed reference model,
// plus directed scenarios for the documented corner cases.
module tb_mem_stage;

    localparam int W  = 256;
    localparam int MB = 4 * W;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, m2r, mr, mw, br, z;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_ex, sdata_ex, pc_ex;
    logic [4:0]  rd_ex;
    logic [2:0]  f3_ex;
    logic        rw_ex, m2r_ex, mr_ex, mw_ex, br_ex, z_ex, flush;
    logic [31:0] ALU_OUT_MEM, PC_Branch_MEM, ALU_DATA_WB;
    logic [4:0]  RD_MEM, RD_WB;
    logic        RegWrite_MEM, PCSrc_MEM, MISALIGN_MEM, RegWrite_WB;

    int chk_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  ref_mem [MB];
    instr_t      m_ex;
    logic        m_ex_ok;
    logic [31:0] m_wb_data;
    logic [4:0]  m_wb_rd;
    logic        m_wb_rw, m_wb_ok;

    mem_stage #(.DMEM_WORDS(W), .AW(8)) dut (
        .clk(clk), .reset(reset),
        .ALU_OUT_EX(alu_ex), .REG_DATA2_EX_FINAL(sdata_ex), .PC_Branch_EX(pc_ex),
        .RD_EX(rd_ex), .FUNCT3_EX(f3_ex),
        .RegWrite_EX(rw_ex), .MemtoReg_EX(m2r_ex), .MemRead_EX(mr_ex),
        .MemWrite_EX(mw_ex), .Branch_EX(br_ex), .ZERO_EX(z_ex), .FLUSH(flush),
        .ALU_OUT_MEM(ALU_OUT_MEM), .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
        .PC_Branch_MEM(PC_Branch_MEM), .PCSrc_MEM(PCSrc_MEM), .MISALIGN_MEM(MISALIGN_MEM),
        .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int acc_bytes(input instr_t i);
        return (i.f3[1:0] == 2'b00) ? 1 : ((i.f3[1:0] == 2'b01) ? 2 : 4);
    endfunction

    function automatic logic ref_misalign(input instr_t i);
        int b;
        b = int'(i.alu % MB);
        return (i.mr || i.mw) && ((b % acc_bytes(i)) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input instr_t i);
        int b, n;
        logic [31:0] v;
        b = int'(i.alu % MB);
        n = acc_bytes(i);
        v = 32'h0;
        if (ref_misalign(i)) begin
            b = b - (b % 4);
            n = 4;
        end
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[b + k]) << (8 * k));
        if (!ref_misalign(i) && n < 4 && !i.f3[2] && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic ref_store(input instr_t i);
        int b;
        b = int'(i.alu % MB);
        for (int k = 0; k < acc_bytes(i); k++) ref_mem[b + k] = 8'(i.sdata >> (8 * k));
    endtask

    function automatic instr_t op_alu(input logic [4:0] rd, input logic [31:0] val);
        instr_t i = '0;
        i.alu = val; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t op_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        instr_t i = '0;
        i.alu = addr; i.f3 = f3; i.rd = rd; i.rw = 1'b1; i.m2r = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic instr_t op_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        instr_t i = '0;
        i.alu = addr; i.f3 = f3; i.sdata = d; i.mw = 1'b1;
        return i;
    endfunction

    function automatic instr_t op_branch(input logic [31:0] pc, input logic z);
        instr_t i = '0;
        i.pc = pc; i.br = 1'b1; i.z = z;
        return i;
    endfunction

    // Present one instruction for one cycle, advance the model, compare outputs.
    task automatic step(input instr_t i, input logic fl, input logic rst);
        {alu_ex, sdata_ex, pc_ex, rd_ex, f3_ex, rw_ex, m2r_ex, mr_ex, mw_ex, br_ex, z_ex} = i;
        flush = fl;
        reset = rst;
        @(posedge clk);
        if (rst) begin
            m_wb_data = 32'h0; m_wb_rd = 5'd0; m_wb_rw = 1'b0; m_wb_ok = 1'b1;
            m_ex = '0; m_ex_ok = 1'b1;
        end else begin
            m_wb_data = m_ex.m2r ? ref_load(m_ex) : m_ex.alu;
            m_wb_rd   = m_ex.rd;
            m_wb_rw   = m_ex.rw;
            m_wb_ok   = m_ex_ok;
            if (m_ex.mw && !ref_misalign(m_ex)) ref_store(m_ex);
            m_ex    = i;
            m_ex_ok = !fl;
            if (fl) begin
                m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0; m_ex.br = 1'b0;
            end
        end
        @(negedge clk);
        check_eq("regwrite_mem", 32'(RegWrite_MEM), 32'(m_ex.rw));
        check_eq("pcsrc_mem", 32'(PCSrc_MEM), 32'(m_ex.br & m_ex.z));
        check_eq("misalign_mem", 32'(MISALIGN_MEM), 32'(ref_misalign(m_ex)));
        check_eq("regwrite_wb", 32'(RegWrite_WB), 32'(m_wb_rw));
        if (m_ex_ok) begin
            check_eq("alu_out_mem", ALU_OUT_MEM, m_ex.alu);
            check_eq("rd_mem", 32'(RD_MEM), 32'(m_ex.rd));
            check_eq("pc_branch_mem", PC_Branch_MEM, m_ex.pc);
        end
        if (m_wb_ok) begin
            check_eq("alu_data_wb", ALU_DATA_WB, m_wb_data);
            check_eq("rd_wb", 32'(RD_WB), 32'(m_wb_rd));
        end
    endtask

    task automatic load_check(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] exp);
        step(op_load(f3, addr, 5'd1), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check_eq(tag, ALU_DATA_WB, exp);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        logic [2:0] lf3 [5];
        lf3[0] = 3'b000; lf3[1] = 3'b001; lf3[2] = 3'b010; lf3[3] = 3'b100; lf3[4] = 3'b101;
        case ($urandom_range(0, 3))
            0:       i = op_alu(5'($urandom), $urandom);
            1:       i = op_load(lf3[$urandom_range(0, 4)], 32'($urandom_range(0, 2047)), 5'($urandom));
            2:       i = op_store(3'($urandom_range(0, 2)), 32'($urandom_range(0, 2047)), $urandom);
            default: i = op_branch($urandom, 1'($urandom));
        endcase
        i.z  = 1'($urandom);
        i.pc = $urandom;
        if (i.br == 1'b0) i.rw = 1'($urandom) | i.mr;
        return i;
    endfunction

    initial begin
        m_ex = '0; m_ex_ok = 1'b1;
        m_wb_data = 32'h0; m_wb_rd = 5'd0; m_wb_rw = 1'b0; m_wb_ok = 1'b1;
        for (int k = 0; k < MB; k++) ref_mem[k] = 8'h00;

        step('0, 1'b0, 1'b1);
        step(op_store(3'b010, 32'h10, 32'h1), 1'b0, 1'b1);
        check_eq("reset_alu_data_wb", ALU_DATA_WB, 32'h0);
        check_eq("reset_alu_out_mem", ALU_OUT_MEM, 32'h0);

        // Give every memory word a known value before anything reads it.
        for (int w = 0; w < W; w++) step(op_store(3'b010, 32'(w * 4), $urandom), 1'b0, 1'b0);

        step(op_store(3'b010, 32'h10, 32'hDEADBEEF), 1'b0, 1'b0);
        load_check("sw_lw", 3'b010, 32'h10, 32'hDEADBEEF);
        step(op_store(3'b000, 32'h11, 32'h0000007F), 1'b0, 1'b0);
        load_check("lb_11", 3'b000, 32'h11, 32'h0000007F);
        load_check("lw_after_sb", 3'b010, 32'h10, 32'hDEAD7FEF);
        load_check("lbu_13", 3'b100, 32'h13, 32'h000000DE);
        load_check("lb_13", 3'b000, 32'h13, 32'hFFFFFFDE);
        load_check("lh_12", 3'b001, 32'h12, 32'hFFFFDEAD);
        load_check("lh_mis", 3'b001, 32'h11, 32'hDEAD7FEF);

        step(op_store(3'b010, 32'h12, 32'h11111111), 1'b0, 1'b0);
        check_eq("sw_misalign", 32'(MISALIGN_MEM), 32'h1);
        load_check("sw_mis_nowrite", 3'b010, 32'h10, 32'hDEAD7FEF);
        step(op_store(3'b001, 32'h13, 32'h2222), 1'b0, 1'b0);
        check_eq("sh_misalign", 32'(MISALIGN_MEM), 32'h1);

        step(op_load(3'b010, 32'h10, 5'd3), 1'b0, 1'b0);
        step(op_store(3'b010, 32'h10, 32'hCAFEF00D), 1'b0, 1'b0);
        check_eq("load_before_store", ALU_DATA_WB, 32'hDEAD7FEF);
        load_check("store_landed", 3'b010, 32'h10, 32'hCAFEF00D);

        step(op_branch(32'h40, 1'b1), 1'b0, 1'b0);
        check_eq("branch_taken", 32'(PCSrc_MEM), 32'h1);
        check_eq("branch_pc", PC_Branch_MEM, 32'h40);
        step(op_branch(32'h40, 1'b1), 1'b1, 1'b0);
        check_eq("branch_flushed", 32'(PCSrc_MEM), 32'h0);

        step(op_store(3'b010, 32'h20, 32'h55555555), 1'b0, 1'b1);
        step(op_store(3'b010, 32'h10, 32'h66666666), 1'b0, 1'b0);
        step('0, 1'b0, 1'b1);
        check_eq("reset_regwrite_wb", 32'(RegWrite_WB), 32'h0);
        check_eq("reset_pcsrc", 32'(PCSrc_MEM), 32'h0);
        load_check("reset_store_dropped", 3'b010, 32'h10, 32'hCAFEF00D);
        step(op_alu(5'd5, 32'h1234), 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        check_eq("post_reset_rd", 32'(RD_WB), 32'h5);
        check_eq("post_reset_data", ALU_DATA_WB, 32'h1234);

        step(op_store(3'b010, 32'h400, 32'hA5A5A5A5), 1'b0, 1'b0);
        load_check("addr_wrap", 3'b010, 32'h0, 32'hA5A5A5A5);

        for (int n = 0; n < 3000; n++) begin
            step(rand_instr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
